// File: rtl/id_ex_register_pkg.sv
// Shared pipeline definitions for the ID/EX register: default widths, NOP ALU op,
// the all-zero bubble control vector and a saturating counter helper.
package id_ex_register_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_ALUOP_W    = 3;
  localparam int CTRL_FLAGS_W   = 6;

  localparam logic [DEF_ALUOP_W-1:0]  ALU_OP_NOP  = 3'b000;
  localparam logic [CTRL_FLAGS_W-1:0] BUBBLE_CTRL = 6'b000000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/id_ex_register_pipe_reg.sv
// Generic W-bit pipeline register: synchronous reset to zero, synchronous clear to
// CLR_VAL, and load enable, with priority rst > clr > en.
module id_ex_register_pipe_reg #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // next-state selection: clear beats enable, otherwise hold
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = CLR_VAL;
    end else if (en) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with hold, flush (bubble insert) and a per-entry valid bit.
// Optional bubble counter output enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ALUOP_W    = DEF_ALUOP_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  reg_dst_in,
  input  logic                  alu_src_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [ALUOP_W-1:0]    alu_op_in,
  input  logic [DATA_W-1:0]     pc_plus4_in,
  input  logic [DATA_W-1:0]     rd_data1_in,
  input  logic [DATA_W-1:0]     rd_data2_in,
  input  logic [DATA_W-1:0]     imm_ext_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rd_data1,
  output logic [DATA_W-1:0]     ex_rd_data2,
  output logic [DATA_W-1:0]     ex_imm_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
`ifdef IDEX_BUBBLE_CNT_EN
  output logic [15:0]           bubble_count,
`endif
  output logic                  ex_valid
);

  localparam int CTRL_W = CTRL_FLAGS_W + ALUOP_W + 1;
  localparam int DBUS_W = 4 * DATA_W + 3 * REG_ADDR_W;
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = {BUBBLE_CTRL, ALUOP_W'(ALU_OP_NOP), 1'b0};

  logic [CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DBUS_W-1:0] dbus_in;
  logic [DBUS_W-1:0] dbus_out;

  assign ctrl_in = {reg_dst_in, alu_src_in, mem_read_in, mem_write_in, reg_write_in,
                    mem_to_reg_in, alu_op_in, valid_in};
  assign dbus_in = {pc_plus4_in, rd_data1_in, rd_data2_in, imm_ext_in, rs_in, rt_in, rd_in};

  id_ex_register_pipe_reg #(.W(CTRL_W), .CLR_VAL(CTRL_BUBBLE)) u_ctrl_reg (
    .clk (clk),
    .rst (reset),
    .clr (flush),
    .en  (en),
    .d   (ctrl_in),
    .q   (ctrl_out)
  );

  // data fields still load on a flush so a bubble's payload is deterministic
  id_ex_register_pipe_reg #(.W(DBUS_W), .CLR_VAL('0)) u_data_reg (
    .clk (clk),
    .rst (reset),
    .clr (1'b0),
    .en  (en | flush),
    .d   (dbus_in),
    .q   (dbus_out)
  );

  assign {ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
          ex_mem_to_reg, ex_alu_op, ex_valid} = ctrl_out;
  assign {ex_pc_plus4, ex_rd_data1, ex_rd_data2, ex_imm_ext, ex_rs, ex_rt, ex_rd} = dbus_out;

`ifdef IDEX_BUBBLE_CNT_EN
  logic        bubble_edge;
  logic [15:0] bubble_count_d;
  logic [15:0] bubble_count_q;

  // a bubble is captured on a flush or on a load of a non-valid entry; holds never count
  always_comb begin
    bubble_edge    = flush | (en & ~valid_in);
    bubble_count_d = bubble_count_q;
    if (bubble_edge) begin
      bubble_count_d = sat_inc16(bubble_count_q);
    end else begin
      bubble_count_d = bubble_count_q;
    end
  end

  // bubble counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count_q <= 16'd0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed steps, expected entries queued by a
// reference model at drive time and compared after each rising edge.
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        reset, en, flush, valid_in;
  logic        reg_dst_in, alu_src_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic [2:0]  alu_op_in;
  logic [31:0] pc_plus4_in, rd_data1_in, rd_data2_in, imm_ext_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic        ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [2:0]  ex_alu_op;
  logic [31:0] ex_pc_plus4, ex_rd_data1, ex_rd_data2, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_valid;
  logic [15:0] bubble_count;

  typedef struct {
    logic        reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    logic [2:0]  alu_op;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        valid;
    logic [15:0] bcnt;
  } exp_t;

  exp_t model;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  id_ex_register dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
    .reg_dst_in(reg_dst_in), .alu_src_in(alu_src_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .alu_op_in(alu_op_in), .pc_plus4_in(pc_plus4_in), .rd_data1_in(rd_data1_in),
    .rd_data2_in(rd_data2_in), .imm_ext_in(imm_ext_in), .rs_in(rs_in), .rt_in(rt_in),
    .rd_in(rd_in), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4),
    .ex_rd_data1(ex_rd_data1), .ex_rd_data2(ex_rd_data2), .ex_imm_ext(ex_imm_ext),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
`ifdef IDEX_BUBBLE_CNT_EN
    .bubble_count(bubble_count),
`endif
    .ex_valid(ex_valid)
  );

`ifndef IDEX_BUBBLE_CNT_EN
  assign bubble_count = 16'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic compare_all(input exp_t e);
    chk("reg_dst",    32'(ex_reg_dst),    32'(e.reg_dst));
    chk("alu_src",    32'(ex_alu_src),    32'(e.alu_src));
    chk("mem_read",   32'(ex_mem_read),   32'(e.mem_read));
    chk("mem_write",  32'(ex_mem_write),  32'(e.mem_write));
    chk("reg_write",  32'(ex_reg_write),  32'(e.reg_write));
    chk("mem_to_reg", 32'(ex_mem_to_reg), 32'(e.mem_to_reg));
    chk("alu_op",     32'(ex_alu_op),     32'(e.alu_op));
    chk("pc_plus4",   ex_pc_plus4,        e.pc);
    chk("rd_data1",   ex_rd_data1,        e.rd1);
    chk("rd_data2",   ex_rd_data2,        e.rd2);
    chk("imm_ext",    ex_imm_ext,         e.imm);
    chk("rs",         32'(ex_rs),         32'(e.rs));
    chk("rt",         32'(ex_rt),         32'(e.rt));
    chk("rd",         32'(ex_rd),         32'(e.rd));
    chk("valid",      32'(ex_valid),      32'(e.valid));
`ifdef IDEX_BUBBLE_CNT_EN
    chk("bubble_cnt", 32'(bubble_count),  32'(e.bcnt));
`endif
  endtask

  // Reference model: reset > flush > hold > load, then one edge and compare.
  task automatic step(input bit do_check);
    exp_t nx;
    exp_t got;
    nx = model;
    if (reset) begin
      nx = '{default: '0};
    end else if (flush || en) begin
      nx.pc = pc_plus4_in;  nx.rd1 = rd_data1_in;  nx.rd2 = rd_data2_in;
      nx.imm = imm_ext_in;  nx.rs = rs_in;  nx.rt = rt_in;  nx.rd = rd_in;
      if (flush) begin
        {nx.reg_dst, nx.alu_src, nx.mem_read, nx.mem_write, nx.reg_write, nx.mem_to_reg} = 6'd0;
        nx.alu_op = 3'd0;
        nx.valid  = 1'b0;
      end else begin
        nx.reg_dst = reg_dst_in;  nx.alu_src = alu_src_in;  nx.mem_read = mem_read_in;
        nx.mem_write = mem_write_in;  nx.reg_write = reg_write_in;
        nx.mem_to_reg = mem_to_reg_in;  nx.alu_op = alu_op_in;  nx.valid = valid_in;
      end
      if ((flush || !valid_in) && nx.bcnt != 16'hFFFF) nx.bcnt = nx.bcnt + 16'd1;
    end
    model = nx;
    sb.push_back(nx);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (do_check) compare_all(got);
  endtask

  task automatic drive_fields(input logic [5:0] ctl, input logic [2:0] op, input logic [31:0] pc,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    {reg_dst_in, alu_src_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in} = ctl;
    alu_op_in = op;  pc_plus4_in = pc;  rd_data1_in = d1;  rd_data2_in = d2;
    imm_ext_in = imm;  rs_in = rs;  rt_in = rt;  rd_in = rd;
  endtask

  task automatic drive_random();
    drive_fields(6'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom,
                 5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  initial begin
    model = '{default: '0};
    // reset with every input high
    reset = 1'b1;  en = 1'b1;  flush = 1'b1;  valid_in = 1'b1;
    drive_fields(6'h3F, 3'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 5'h1F, 5'h1F, 5'h1F);
    step(1'b1);
    step(1'b1);
    chk("reset_valid", 32'(ex_valid), 32'd0);

    // basic load
    reset = 1'b0;  flush = 1'b0;  en = 1'b1;  valid_in = 1'b1;
    drive_fields(6'b100110, 3'b101, 32'h0000_0104, 32'hDEADBEEF, 32'h1234_5678, 32'h0000_0FFF,
                 5'd3, 5'd9, 5'd17);
    step(1'b1);
    chk("load_alu_op", 32'(ex_alu_op), 32'd5);
    chk("load_rd1", ex_rd_data1, 32'hDEADBEEF);
    chk("load_rt", 32'(ex_rt), 32'd9);
    chk("load_valid", 32'(ex_valid), 32'd1);

    // hold for three cycles while inputs change
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      valid_in = 1'(i);
      step(1'b1);
      chk("hold_rd1", ex_rd_data1, 32'hDEADBEEF);
    end

    // flush overrides hold; data still loads
    flush = 1'b1;  en = 1'b0;  valid_in = 1'b1;
    drive_fields(6'b000010, 3'b011, 32'h200, 32'h1, 32'h2, 32'h10, 5'd1, 5'd2, 5'd3);
    step(1'b1);
    chk("flush_reg_write", 32'(ex_reg_write), 32'd0);
    chk("flush_imm", ex_imm_ext, 32'h10);

    // non-valid entry keeps its controls
    flush = 1'b0;  en = 1'b1;  valid_in = 1'b0;
    drive_fields(6'b111111, 3'b110, 32'h300, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h80, 5'd4, 5'd5, 5'd6);
    step(1'b1);

    // a few random loads with mixed valid
    for (int i = 0; i < 6; i++) begin
      drive_random();
      valid_in = 1'($urandom);
      step(1'b1);
    end

    // reset concurrent with flush after a valid entry
    valid_in = 1'b1;
    drive_random();
    step(1'b1);
    reset = 1'b1;  flush = 1'b1;
    drive_random();
    step(1'b1);
    chk("rst_flush_pc", ex_pc_plus4, 32'd0);

`ifdef IDEX_BUBBLE_CNT_EN
    // two flushes, one non-valid load, one hold
    reset = 1'b0;  flush = 1'b1;  en = 1'b1;  valid_in = 1'b1;
    step(1'b1);
    step(1'b1);
    flush = 1'b0;  valid_in = 1'b0;
    step(1'b1);
    en = 1'b0;
    step(1'b1);
    chk("bubble_cnt3", 32'(bubble_count), 32'd3);
    // run to saturation and past it
    flush = 1'b1;
    for (int i = 0; i < 65540; i++) step(1'b0);
    compare_all(model);
    chk("bubble_sat", 32'(bubble_count), 32'h0000FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
